// File: rtl/sram_arb_pkg.sv
// ============================================================================
// Module : sram_arb_pkg
// Brief  : Shared types and default sizes for the SRAM port arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package sram_arb_pkg;

    localparam int c_default_addr_w      = 18;
    localparam int c_default_data_w      = 16;
    localparam int c_default_timeout_cyc = 64;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        RELEASE   = 2'd3
    } sram_arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// Module : rr_picker
// Brief  : Round-robin winner select; the search starts one above the pointer.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_win_onehot,
    output logic [IDX_W-1:0]   o_win_idx
);

    logic [NUM_REQ-1:0] w_rot;
    int                 w_off;
    int                 w_sum;

    // Doubling the vector turns the wrap-around search into a plain shift.
    always_comb begin
        w_rot = NUM_REQ'({i_req, i_req} >> (int'(i_ptr) + 1));
        w_off = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = k;
            end
        end
        w_sum = int'(i_ptr) + 1 + w_off;
        if (w_sum >= NUM_REQ) begin
            w_sum = w_sum - NUM_REQ;
        end
        o_win_idx    = IDX_W'(w_sum);
        o_win_onehot = (|i_req) ? (NUM_REQ'(1) << o_win_idx) : '0;
    end

endmodule

`default_nettype wire

// File: rtl/sram_arbiter.sv
// ============================================================================
// Module : sram_arbiter
// Brief  : Round-robin, burst-limited sharing of one SRAM controller port.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int ADDR_W      = c_default_addr_w,
    parameter int DATA_W      = c_default_data_w,
    parameter int MAX_BURST   = 4,
    parameter int TIMEOUT_CYC = c_default_timeout_cyc
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rdata,
    output logic                      timeout_err,
    output logic                      sram_read_en,
    output logic                      sram_wr_en,
    output logic [ADDR_W-1:0]         sram_address,
    output logic [DATA_W-1:0]         sram_wr_data,
    input  logic                      sram_read_valid,
    input  logic                      sram_wr_valid,
    input  logic [DATA_W-1:0]         sram_read_data
);

    localparam int         c_idx_w      = $clog2(NUM_REQ);
    localparam logic [7:0] c_wd_last    = 8'(TIMEOUT_CYC - 1);
    localparam logic [3:0] c_burst_last = 4'(MAX_BURST - 1);

    sram_arb_state_t      r_state, w_state;
    logic [c_idx_w-1:0]   r_ptr, w_ptr;
    logic [c_idx_w-1:0]   r_owner, w_owner;
    logic [3:0]           r_burst, w_burst;
    logic [7:0]           r_wd, w_wd;
    logic                 r_we, w_we;
    logic [ADDR_W-1:0]    r_addr, w_addr;
    logic [DATA_W-1:0]    r_wdata, w_wdata;
    logic [NUM_REQ-1:0]   r_gnt, w_gnt;
    logic [NUM_REQ-1:0]   r_done, w_done;
    logic [DATA_W-1:0]    r_rdata, w_rdata;
    logic                 r_tmo, w_tmo;
    logic                 r_rd_en, w_rd_en;
    logic                 r_wr_en, w_wr_en;

    logic [NUM_REQ-1:0]   w_win_onehot;
    logic [c_idx_w-1:0]   w_win_idx;
    logic                 w_resp;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_idx_w)
    ) u_picker (
        .i_req        (req),
        .i_ptr        (r_ptr),
        .o_win_onehot (w_win_onehot),
        .o_win_idx    (w_win_idx)
    );

    // Only the response type matching the latched direction ends the wait.
    assign w_resp = r_we ? sram_wr_valid : sram_read_valid;

    always_comb begin
        w_state = r_state;
        w_ptr   = r_ptr;
        w_owner = r_owner;
        w_burst = r_burst;
        w_wd    = r_wd;
        w_we    = r_we;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        w_gnt   = r_gnt;
        w_done  = '0;
        w_rdata = r_rdata;
        w_tmo   = 1'b0;
        w_rd_en = r_rd_en;
        w_wr_en = r_wr_en;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_owner = w_win_idx;
                    w_we    = req_we[w_win_idx];
                    w_addr  = req_addr[w_win_idx*ADDR_W +: ADDR_W];
                    w_wdata = req_wdata[w_win_idx*DATA_W +: DATA_W];
                    w_gnt   = w_win_onehot;
                    w_state = ISSUE;
                end
            end
            ISSUE: begin
                w_rd_en = ~r_we;
                w_wr_en = r_we;
                w_wd    = '0;
                w_state = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (w_resp) begin
                    if (!r_we) begin
                        w_rdata = sram_read_data;
                    end
                    w_done  = NUM_REQ'(1) << r_owner;
                    w_rd_en = 1'b0;
                    w_wr_en = 1'b0;
                    w_state = RELEASE;
                end else if (r_wd == c_wd_last) begin
                    w_tmo   = 1'b1;
                    w_done  = NUM_REQ'(1) << r_owner;
                    w_rd_en = 1'b0;
                    w_wr_en = 1'b0;
                    w_burst = '0;
                    w_state = RELEASE;
                end else begin
                    w_wd = r_wd + 8'd1;
                end
            end
            RELEASE: begin
                if (req[r_owner] && (r_burst < c_burst_last)) begin
                    w_burst = r_burst + 4'd1;
                    w_we    = req_we[r_owner];
                    w_addr  = req_addr[r_owner*ADDR_W +: ADDR_W];
                    w_wdata = req_wdata[r_owner*DATA_W +: DATA_W];
                    w_state = ISSUE;
                end else begin
                    w_ptr   = r_owner;
                    w_burst = '0;
                    w_gnt   = '0;
                    w_state = IDLE;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_ptr   <= c_idx_w'(NUM_REQ - 1);
            r_owner <= '0;
            r_burst <= '0;
            r_wd    <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_rdata <= '0;
            r_tmo   <= 1'b0;
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
        end else begin
            r_state <= w_state;
            r_ptr   <= w_ptr;
            r_owner <= w_owner;
            r_burst <= w_burst;
            r_wd    <= w_wd;
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_gnt   <= w_gnt;
            r_done  <= w_done;
            r_rdata <= w_rdata;
            r_tmo   <= w_tmo;
            r_rd_en <= w_rd_en;
            r_wr_en <= w_wr_en;
        end
    end

    assign gnt          = r_gnt;
    assign done         = r_done;
    assign rdata        = r_rdata;
    assign timeout_err  = r_tmo;
    assign sram_read_en = r_rd_en;
    assign sram_wr_en   = r_wr_en;
    assign sram_address = r_addr;
    assign sram_wr_data = r_wdata;

endmodule

`default_nettype wire

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external-SRAM controller port among NUM_REQ requesters, e.g. camera write, VGA read and filter pipeline.
- Uses round-robin arbitration with a bounded burst per grant.
- Serialises single-word read/write transactions and holds the controller's read_en/wr_en until the controller returns read_valid/wr_valid.
- A watchdog aborts transactions that hang.
- Sits between the image-processing masters and the SRAM controller.

Parameters:
- NUM_REQ, 3: number of requesters (2..8).
- ADDR_W, 18: SRAM word address width.
- DATA_W, 16: SRAM data width.
- MAX_BURST, 4: maximum consecutive transactions granted to one requester before the grant must rotate (1..15).
- TIMEOUT_CYC, 64: cycles to wait for valid before aborting (fits in 8 bits).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester transaction request; level, held until done.
- req_we  in  NUM_REQ  1 = write, 0 = read; valid while req is high.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  flattened write data, same packing.
- gnt  out  NUM_REQ  one-hot; marks the owner of the current transaction.
- done  out  NUM_REQ  one-cycle pulse to the owner when its transaction completes.
- rdata  out  DATA_W  read data; valid on the cycle done is high for a read.
- timeout_err  out  1  one-cycle pulse when a transaction is aborted.
- sram_read_en  out  1  to controller read_en.
- sram_wr_en  out  1  to controller wr_en.
- sram_address  out  ADDR_W  to controller address.
- sram_wr_data  out  DATA_W  to controller write data.
- sram_read_valid  in  1  from controller.
- sram_wr_valid  in  1  from controller.
- sram_read_data  in  DATA_W  from controller.

Behaviour:
- Reset (rst low, asynchronous):
  - State = IDLE; all outputs registered and 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority; burst count = 0; watchdog = 0.
- States: IDLE, ISSUE, WAIT_RESP, RELEASE.
- IDLE:
  - If any req is high, pick the winner: first requester with req set, searching from pointer+1 upward with wrap-around.
  - On the next edge: latch its addr, we and wdata; set gnt one-hot; go to ISSUE.
  - With no req, stay in IDLE with gnt = 0.
- ISSUE (one cycle): assert sram_read_en or sram_wr_en per the latched we, drive sram_address and sram_wr_data from the latches, clear the watchdog, go to WAIT_RESP.
- WAIT_RESP:
  - Hold the enable, address and data stable; increment the watchdog.
  - On sram_read_valid (read) or sram_wr_valid (write):
    - Capture sram_read_data into rdata (reads only).
    - Pulse done[owner] on the next cycle.
    - Deassert the enable; go to RELEASE.
  - A valid of the wrong type is ignored.
  - If the watchdog reaches TIMEOUT_CYC-1 without valid: pulse timeout_err and done[owner], leave rdata unchanged, deassert the enable, go to RELEASE, and reset the burst count to 0.
- RELEASE (one cycle, enable low): lets the controller return to its idle state.
  - If the owner's req is still high and burst count < MAX_BURST-1: increment the burst count, latch the new addr/we/wdata, go to ISSUE, and keep gnt.
  - Otherwise: set pointer = owner, burst count = 0, gnt = 0, go to IDLE.
- Latency: req high in IDLE at cycle 0 gives enable high at cycle 2.
  - With a controller that answers in 1 cycle (valid seen at cycle 3), done is high at cycle 4.
  - Back-to-back transactions in a burst: one transaction every 4 cycles.
- Requesters must hold req/addr/we/wdata until their done. Dropping req mid-transaction does not cancel the transaction; it only stops a burst continuation.
- Simultaneous requests are resolved by the pointer alone; there is no fixed priority.
- Exactly one of sram_read_en and sram_wr_en is ever high, and never in IDLE or RELEASE.
- gnt changes only on IDLE→ISSUE and RELEASE→IDLE edges.
- Reset mid-transaction: outputs drop immediately (asynchronous); no done is issued for the aborted transaction.

Decomposition:
- Package sram_arb_pkg: state enum sram_arb_state_t (IDLE, ISSUE, WAIT_RESP, RELEASE), and the localparams for default ADDR_W, DATA_W and TIMEOUT_CYC.
- Sub-module rr_picker (combinational): inputs are the req vector and pointer; outputs are the one-hot winner and its index, produced by a double-width rotate-and-priority-encode.
- The arbiter FSM, latches and watchdog stay in sram_arbiter.

Test Plan:
- Single read: req[1]=1, we=0, addr=18'h00ABC; controller model returns 16'h5A5A on its first valid → gnt=3'b010, sram_read_en high from cycle 2, done[1] pulse with rdata=16'h5A5A, then gnt=0.
- Contention: req=3'b111 from reset, each requester drops req after its first done → grant order 0,1,2; the next request from 0 is granted after 2.
- Burst limit: req[0] held high for 6 transactions, req[2] also high → requester 0 gets 4 consecutive dones (MAX_BURST), then requester 2 gets one, then requester 0 resumes.
- Write then read: requester 2 writes 16'hBEEF to 18'h3FFFF, then reads it back from the SRAM model → sram_wr_data=16'hBEEF while sram_wr_en is high; read returns rdata=16'hBEEF; enables are never high together.
- Timeout: controller model never asserts valid → timeout_err and done pulse after TIMEOUT_CYC cycles in WAIT_RESP, FSM returns to IDLE, the next requester is granted.
- Reset mid-transaction: rst low during WAIT_RESP → all outputs 0 within the same cycle; after release, requester 0 has priority and no stray done appears.
